// File: rtl/sim_ctrl_dev.sv
`default_nettype none
// ============================================================================
// Module      : sim_ctrl_dev
// Description : Memory-mapped simulation-control device on the data bus.
//               Stores to SIG_ADDR are queued in a FIFO and streamed out on a
//               valid/ready port. A store to HALT_ADDR freezes the cycle
//               counter, lets the FIFO drain, then raises halted. Loads from
//               CYCLE_ADDR return the cycle counter.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               addr, data_in,
//               write_en, read_en - core data-bus request
//               hit, stall        - combinational bus responses
//               data_out          - registered load data
//               sig_valid, sig_data, sig_ready - signature stream
//               halted, halt_code - halt status and captured halt code
//               cycle_count       - free-running counter, frozen at halt
// Revision    : 1.0 - initial release
// ============================================================================
module sim_ctrl_dev #(
    parameter int          DATA_WIDTH = 32,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] SIG_ADDR   = 32'h8E00_0000,
    parameter logic [31:0] HALT_ADDR  = 32'h8F00_0000,
    parameter logic [31:0] CYCLE_ADDR = 32'h8F00_0004
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_en,
    input  logic                  read_en,
    output logic                  hit,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  sig_valid,
    output logic [DATA_WIDTH-1:0] sig_data,
    input  logic                  sig_ready,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] halt_code,
    output logic [31:0]           cycle_count
);

    localparam int               c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_PTR_ONE = {{c_PTR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // FIFO storage and pointers; the extra MSB is the wrap bit that tells
    // full from empty when the index bits match.
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]      r_wr_ptr;
    logic [c_PTR_W:0]      r_rd_ptr;

    logic [31:0]           r_cycle;
    logic [DATA_WIDTH-1:0] r_halt_code;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic w_sig_sel;
    logic w_halt_sel;
    logic w_cycle_sel;
    logic w_sig_wr;
    logic w_halt_acc;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_run;

    // ------------------------------------------------------------------
    // Address decode and bus responses
    // ------------------------------------------------------------------
    assign w_sig_sel   = (addr == SIG_ADDR);
    assign w_halt_sel  = (addr == HALT_ADDR);
    assign w_cycle_sel = (addr == CYCLE_ADDR);
    assign w_run       = (r_state == ST_RUN);

    assign w_sig_wr    = write_en && w_sig_sel;
    assign w_halt_acc  = write_en && w_halt_sel && w_run;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

    // Full is judged before any same-cycle pop, so a store into a full
    // FIFO always waits at least one cycle.
    assign w_push = w_sig_wr && w_run && !w_full;
    assign w_pop  = !w_empty && sig_ready;

    assign hit   = (write_en || read_en) && (w_sig_sel || w_halt_sel || w_cycle_sel);
    assign stall = w_sig_wr && w_full && w_run;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and status output
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        halted       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_halt_acc) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Looks at the registered pointers, so a FIFO emptied by a
                // pop at edge M is seen here and HALTED is entered at M+1.
                if (w_empty) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage needs no reset; contents are discarded by clearing pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= data_in;
        end
    end

    assign sig_valid = !w_empty;
    assign sig_data  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    // ------------------------------------------------------------------
    // Cycle counter, halt code and load data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle     <= 32'd0;
            r_halt_code <= '0;
            r_data_out  <= '0;
        end else begin
            // The halt-accepting cycle is already frozen.
            if (w_run && !w_halt_acc) begin
                r_cycle <= r_cycle + 32'd1;
            end
            if (w_halt_acc) begin
                r_halt_code <= data_in;
            end
            if (read_en && w_cycle_sel) begin
                r_data_out <= DATA_WIDTH'(r_cycle);
            end else if (read_en && (w_sig_sel || w_halt_sel)) begin
                r_data_out <= '0;
            end
        end
    end

    assign cycle_count = r_cycle;
    assign halt_code   = r_halt_code;
    assign data_out    = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_sim_ctrl_dev.sv
`default_nettype none
// ============================================================================
// Module      : tb_sim_ctrl_dev
// Description : Directed self-checking bench for sim_ctrl_dev. Inputs change
//               1 time unit after the rising edge; outputs are sampled there.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_ctrl_dev;

    localparam logic [31:0] c_SIG   = 32'h8E00_0000;
    localparam logic [31:0] c_HALT  = 32'h8F00_0000;
    localparam logic [31:0] c_CYCLE = 32'h8F00_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic        hit;
    logic        stall;
    logic [31:0] data_out;
    logic        sig_valid;
    logic [31:0] sig_data;
    logic        sig_ready = 1'b0;
    logic        halted;
    logic [31:0] halt_code;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    sim_ctrl_dev dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .data_in     (data_in),
        .write_en    (write_en),
        .read_en     (read_en),
        .hit         (hit),
        .stall       (stall),
        .data_out    (data_out),
        .sig_valid   (sig_valid),
        .sig_data    (sig_data),
        .sig_ready   (sig_ready),
        .halted      (halted),
        .halt_code   (halt_code),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        write_en = 1'b0;
        read_en  = 1'b0;
        addr     = '0;
        data_in  = '0;
    endtask

    task automatic reset_dut();
        idle_bus();
        sig_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_bus();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %0d want 0", cycle_count); end
        checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL reset_sig_valid: got %b want 0", sig_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (halt_code !== 32'd0) begin errors++; $display("FAIL reset_halt_code: got %h want 0", halt_code); end
        checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        repeat (10) tick();
        checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL idle_cycle: got %0d want 10", cycle_count); end
        checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL idle_sig_valid: got %b want 0", sig_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL idle_halted: got %b want 0", halted); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL idle_hit: got %b want 0", hit); end
    endtask

    task automatic test_stream();
        sig_ready = 1'b1;
        write_en  = 1'b1;
        addr      = c_SIG;
        data_in   = 32'hDEADBEEF;
        #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL stream_hit: got %b want 1", hit); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stream_stall: got %b want 0", stall); end
        checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL stream_no_bypass: got %b want 0", sig_valid); end
        tick();
        checks++; if (sig_valid !== 1'b1) begin errors++; $display("FAIL stream_valid0: got %b want 1", sig_valid); end
        checks++; if (sig_data !== 32'hDEADBEEF) begin errors++; $display("FAIL stream_word0: got %h want deadbeef", sig_data); end
        data_in = 32'h0000_0001;
        tick();
        checks++; if (sig_valid !== 1'b1) begin errors++; $display("FAIL stream_valid1: got %b want 1", sig_valid); end
        checks++; if (sig_data !== 32'h0000_0001) begin errors++; $display("FAIL stream_word1: got %h want 00000001", sig_data); end
        idle_bus();
        tick();
        checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b want 0", sig_valid); end
        sig_ready = 1'b0;
    endtask

    // Runs straight after test_stream so the pointers start at 2 and the
    // nine pushes cross the wrap bit.
    task automatic test_full_wrap();
        int          got;
        int          acc_iter;
        logic        st;
        logic [31:0] exp_w;
        sig_ready = 1'b0;
        write_en  = 1'b1;
        addr      = c_SIG;
        for (int i = 0; i < 8; i++) begin
            data_in = 32'h100 + 32'(i);
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d: got %b want 0", i, stall); end
            tick();
        end
        data_in = 32'h108;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", stall); end
        tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall_held: got %b want 1", stall); end
        checks++; if (sig_data !== 32'h100) begin errors++; $display("FAIL full_head: got %h want 00000100", sig_data); end
        sig_ready = 1'b1;
        got = 0;
        acc_iter = -1;
        for (int it = 0; it < 20 && got < 9; it++) begin
            #1;
            st = stall;
            if (it == 0) begin
                checks++; if (st !== 1'b1) begin errors++; $display("FAIL full_pop_stall: got %b want 1", st); end
            end
            if (sig_valid) begin
                exp_w = 32'h100 + 32'(got);
                checks++; if (sig_data !== exp_w) begin errors++; $display("FAIL wrap_word_%0d: got %h want %h", got, sig_data, exp_w); end
                got++;
            end
            tick();
            if (write_en && !st) begin
                acc_iter = it;
                idle_bus();
            end
        end
        checks++; if (acc_iter !== 1) begin errors++; $display("FAIL stalled_accept_cycle: got %0d want 1", acc_iter); end
        checks++; if (got !== 9) begin errors++; $display("FAIL wrap_count: got %0d want 9", got); end
        idle_bus();
        sig_ready = 1'b0;
    endtask

    task automatic test_halt_drain();
        reset_dut();
        write_en = 1'b1;
        addr     = c_SIG;
        for (int i = 0; i < 3; i++) begin
            data_in = 32'hA0 + 32'(i);
            tick();
        end
        addr    = c_HALT;
        data_in = 32'h0000_002A;
        tick();
        checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL halt_cycle_frozen: got %0d want 3", cycle_count); end
        checks++; if (halt_code !== 32'd42) begin errors++; $display("FAIL halt_code: got %0d want 42", halt_code); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early0: got %b want 0", halted); end
        idle_bus();
        tick();
        tick();
        checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL drain_cycle: got %0d want 3", cycle_count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early1: got %b want 0", halted); end
        sig_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (sig_valid !== 1'b1 || sig_data !== 32'hA0 + 32'(i)) begin
                errors++; $display("FAIL drain_word_%0d: got v=%b %h want v=1 %h", i, sig_valid, sig_data, 32'hA0 + 32'(i));
            end
            tick();
        end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_at_last_pop: got %b want 0", halted); end
        checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", sig_valid); end
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_rise: got %b want 1", halted); end
        checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL halted_cycle: got %0d want 3", cycle_count); end
    endtask

    task automatic test_post_halt();
        write_en = 1'b1;
        addr     = c_SIG;
        data_in  = 32'h55;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_halt_stall: got %b want 0", stall); end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL post_halt_hit: got %b want 1", hit); end
        tick();
        checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL post_halt_push: got %b want 0", sig_valid); end
        addr    = c_HALT;
        data_in = 32'h7;
        tick();
        checks++; if (halt_code !== 32'd42) begin errors++; $display("FAIL post_halt_code: got %0d want 42", halt_code); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL post_halt_halted: got %b want 1", halted); end
        idle_bus();
        read_en = 1'b1;
        addr    = c_CYCLE;
        tick();
        checks++; if (data_out !== 32'd3) begin errors++; $display("FAIL halted_load_cycle: got %0d want 3", data_out); end
        addr = c_SIG;
        tick();
        checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL load_sig_addr: got %h want 0", data_out); end
        idle_bus();
        sig_ready = 1'b0;
    endtask

    task automatic test_load();
        reset_dut();
        repeat (20) tick();
        read_en = 1'b1;
        addr    = c_CYCLE;
        #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL load_hit: got %b want 1", hit); end
        tick();
        checks++; if (data_out !== 32'd20) begin errors++; $display("FAIL load_cycle20: got %0d want 20", data_out); end
        addr = 32'h1000_0000;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL nondev_hit: got %b want 0", hit); end
        tick();
        checks++; if (data_out !== 32'd20) begin errors++; $display("FAIL nondev_hold: got %0d want 20", data_out); end
        addr = c_HALT;
        tick();
        checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL load_halt_addr: got %h want 0", data_out); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL load_halt_side: got %b want 0", halted); end
        idle_bus();
    endtask

    task automatic test_reset_mid_drain();
        reset_dut();
        repeat (5) tick();
        read_en = 1'b1;
        addr    = c_CYCLE;
        tick();
        idle_bus();
        checks++; if (data_out !== 32'd5) begin errors++; $display("FAIL pre_rst_load: got %0d want 5", data_out); end
        write_en = 1'b1;
        addr     = c_SIG;
        for (int i = 0; i < 4; i++) begin
            data_in = 32'hC0 + 32'(i);
            tick();
        end
        addr    = c_HALT;
        data_in = 32'h9;
        tick();
        idle_bus();
        checks++; if (sig_valid !== 1'b1 || halt_code !== 32'h9) begin
            errors++; $display("FAIL pre_rst_drain: got v=%b code=%h want v=1 code=9", sig_valid, halt_code);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL mid_rst_cycle: got %0d want 0", cycle_count); end
        checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", sig_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mid_rst_halted: got %b want 0", halted); end
        checks++; if (halt_code !== 32'd0) begin errors++; $display("FAIL mid_rst_code: got %h want 0", halt_code); end
        checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL mid_rst_data_out: got %h want 0", data_out); end
        tick();
        checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL post_rst_run: got %0d want 1", cycle_count); end
        write_en = 1'b1;
        addr     = c_SIG;
        data_in  = 32'h77;
        tick();
        idle_bus();
        checks++; if (sig_valid !== 1'b1 || sig_data !== 32'h77) begin
            errors++; $display("FAIL post_rst_push: got v=%b %h want v=1 00000077", sig_valid, sig_data);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_wrap();
        test_halt_drain();
        test_post_halt();
        test_load();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sim_ctrl_dev.md
# sim_ctrl_dev

Memory-mapped simulation-control device on the core's data-memory bus, the hardware end of the compliance-test store protocol. Software stores to the signature address are captured into a FIFO and streamed out on a valid/ready port. A store to the halt address freezes the cycle counter, drains the FIFO and raises `halted`. The bench then only consumes the signature stream and waits for `halted`, instead of snooping memory internals.

## Interface
- `DATA_WIDTH`, 32: bus data width and width of the signature stream.
- `FIFO_DEPTH`, 8: signature FIFO entries; must be a power of two and at least 2.
- `SIG_ADDR`, 32'h8E00_0000: store address that pushes a signature word.
- `HALT_ADDR`, 32'h8F00_0000: store address that requests halt; the store data is the halt code.
- `CYCLE_ADDR`, 32'h8F00_0004: load address that returns the cycle counter.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  32  bus address, qualified by `write_en` or `read_en`.
- `data_in`  in  DATA_WIDTH  store data.
- `write_en`  in  1  store strobe.
- `read_en`  in  1  load strobe.
- `hit`  out  1  combinational; `addr` equals one of the three device addresses and `write_en` or `read_en` is high.
- `stall`  out  1  combinational; a signature store is present but cannot be accepted this cycle. The core holds the store.
- `data_out`  out  DATA_WIDTH  registered load data.
- `sig_valid`  out  1  the FIFO head is valid.
- `sig_data`  out  DATA_WIDTH  FIFO head word.
- `sig_ready`  in  1  the consumer accepts the head word.
- `halted`  out  1  halt is complete and the FIFO is empty.
- `halt_code`  out  DATA_WIDTH  data captured by the halt store.
- `cycle_count`  out  32  free-running cycle count, frozen at halt.

## Operation
State machine, reset state RUN:
- RUN → DRAIN on an accepted halt store (`write_en` with `addr==HALT_ADDR`).
- DRAIN → HALTED when the FIFO is empty. If the FIFO is already empty when the halt is accepted, DRAIN lasts exactly 1 cycle.
- HALTED is held until `rst`.

Signature push:
- A push occurs when `write_en`, `addr==SIG_ADDR`, state is RUN and the FIFO is not full.
- `stall` = `write_en` and `addr==SIG_ADDR` and full and state RUN.

FIFO pop:
- A pop occurs when `sig_valid` and `sig_ready` are both high.
- Pops continue in every state, including HALTED.
- Pointers are log2(FIFO_DEPTH) bits plus a wrap bit; both wrap modulo 2·FIFO_DEPTH.
- Simultaneous push and pop when not full: occupancy is unchanged.
- When full, a push is refused even if a pop occurs in the same cycle. Full is evaluated before the pop.

Writes:
- Signature stores and halt stores received in DRAIN or HALTED are ignored. `stall` stays 0 and no state changes.
- Loads from SIG_ADDR or HALT_ADDR return 0 and have no side effect.

Cycle counter:
- 32 bits, +1 every cycle in RUN, wraps from 2^32−1 to 0.
- Frozen in DRAIN and HALTED. The cycle that accepts the halt store does not increment it.

`halt_code` is loaded on the accepted halt store and held thereafter.

## Timing
- Reset values: `cycle_count`=0, `data_out`=0, `halt_code`=0, `halted`=0, `sig_valid`=0, FIFO empty, state RUN.
- `sig_data` is don't-care while `sig_valid`=0.
- Push latency: a word pushed at edge N has `sig_valid`=1 in cycle N+1. There is no bypass from an empty FIFO.
- Load latency: `data_out` is valid 1 cycle after `read_en`. It holds until the next load; a non-device load does not change it.
- `halted` rises on the edge that enters HALTED. That is edge N+1 after a halt store at edge N with the FIFO empty, and otherwise the edge after the last pop.
- `rst` asserted mid-operation: on the next edge all state returns to reset values and FIFO contents are discarded.

## Test plan
- Reset, then 10 idle cycles → `cycle_count`=10, `sig_valid`=0, `halted`=0, `hit`=0.
- With `sig_ready`=1, store 32'hDEADBEEF then 32'h0000_0001 to SIG_ADDR → stream delivers both words in order. Each word appears on `sig_data` one cycle after its store.
- With `sig_ready`=0, issue 9 signature stores (FIFO_DEPTH=8) → 9th store sees `stall`=1. Raise `sig_ready` → 9th store is accepted the cycle after the first pop. All 9 words arrive in order, with a full/empty pointer wrap crossed.
- Push 3 words with `sig_ready`=0, then store 32'h0000_002A to HALT_ADDR, then raise `sig_ready` → `cycle_count` frozen, `halt_code`=42, `halted`=1 exactly the cycle after the 3rd pop.
- After halt, store to SIG_ADDR and HALT_ADDR → no push, `stall`=0, `halt_code` unchanged.
- Load CYCLE_ADDR at cycle 20 → `data_out`=20 on the following cycle.
- Assert `rst` with 4 words queued in DRAIN → all outputs return to reset values the next cycle.
